simplez_uart_tx: RTL and testbench
==================================

SIMPLEZ_UART_TX -- requirements
Module: simplez_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 104, SHALL set clk cycles per serial bit (12 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 data  input  8  byte written by the Simplez output port.
REQ-005 wr  input  1  write strobe; byte on data SHALL be accepted in any cycle where wr=1 and ready=1.
REQ-006 ready  output  1  high when the holding register is empty and a write can be accepted.
REQ-007 busy  output  1  high while a frame is on the line or a byte is pending.
REQ-008 tx  output  1  serial line, idle high, 8N1, LSB first.

Function
REQ-009 Block SHALL contain a 1-byte holding register (hold, hold_valid) and a 10-bit shift register feeding tx.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-011 Baud counter SHALL be 16 bits, SHALL reload to 0 on every state entry, and SHALL generate a bit_tick when it reaches BAUD_DIV-1.
REQ-012 Accepted write (wr & ready) SHALL load hold and set hold_valid; ready SHALL go low the following cycle.
REQ-013 wr with ready=0 SHALL be ignored with no change to hold or the frame in progress.
REQ-014 IDLE with hold_valid=1 SHALL move to START next cycle, copy hold into the shifter and clear hold_valid in the same edge.
REQ-015 START SHALL drive tx=0 for exactly BAUD_DIV cycles, then enter DATA.
REQ-016 DATA SHALL drive data bits 0..7 in order, each for exactly BAUD_DIV cycles; a 3-bit bit index SHALL advance on bit_tick and leave DATA after bit 7.
REQ-017 STOP SHALL drive tx=1 for exactly BAUD_DIV cycles.
REQ-018 At STOP end with hold_valid=1 the FSM SHALL go directly to START (back-to-back, no idle bit), loading the next byte; otherwise it SHALL go to IDLE.
REQ-019 Holding register SHALL be writable during START/DATA/STOP once cleared in REQ-014, so a second byte can be queued during a frame.
REQ-020 tx SHALL be registered (glitch-free); latency from accepted wr in IDLE to tx falling edge SHALL be 2 clk cycles.
REQ-021 ready SHALL equal ~hold_valid; busy SHALL equal (state!=IDLE) | hold_valid.
REQ-022 Frame length SHALL be exactly 10*BAUD_DIV cycles from tx falling edge to end of stop bit.

Reset
REQ-023 rst=1 SHALL immediately, without clk, force state=IDLE, tx=1, hold_valid=0, ready=1, busy=0, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard any pending byte; tx SHALL return high within the same cycle.
REQ-025 After rst deasserts, the first write SHALL be accepted on the first clk edge where wr=1.

Verification (BAUD_DIV=4 for simulation)
REQ-026 Single byte: wr with data=0x55 in IDLE -> tx low 2 cycles later, sequence 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy low after 40 cycles.
REQ-027 Back-to-back: write 0x41 then 0x0F as soon as ready returns -> two contiguous frames, 80 cycles total, no idle cycles between stop and second start bit.
REQ-028 Overrun: third write (0xFF) while ready=0 -> ignored; only 0x41 and 0x0F appear on tx.
REQ-029 Reset mid-frame: rst pulse during DATA bit 3 of 0xA5 -> tx=1, ready=1, busy=0 asynchronously; subsequent 0x3C transmits correctly.
REQ-030 Boundary bytes: 0x00 and 0xFF -> 8 low bits / 8 high bits with correct start/stop framing; a bench UART receiver model SHALL decode each written byte identically.

Source files
------------

// File: rtl/simplez_uart_tx.sv
// Simplez output-port UART transmitter: 1-byte holding register feeding an
// 8N1 shifter, LSB first, BAUD_DIV clk cycles per serial bit.
module simplez_uart_tx #(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] TICK_AT = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [9:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        tx_q, tx_d;
  logic        bit_tick;
  logic        accept;
  logic        load;

  assign bit_tick = (state_q != IDLE) && (cnt_q == TICK_AT);
  assign accept   = wr && !hold_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '1;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_valid_q) state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_tick) state_d = hold_valid_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next-state view of the shifter, so the line
  // changes on the same edge the FSM moves, with no extra pipeline cycle.
  always_comb begin
    load = (state_d == START) && (state_q != START);

    if ((state_q == IDLE) || (state_d != state_q) || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    bit_idx_d = bit_idx_q;
    if (load) begin
      bit_idx_d = '0;
    end else if ((state_q == DATA) && bit_tick) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end

    shift_d = shift_q;
    if (load) begin
      shift_d = {1'b1, hold_q, 1'b0};
    end else if (bit_tick) begin
      shift_d = {1'b1, shift_q[9:1]};
    end

    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_d       = data;
      hold_valid_d = 1'b1;
    end

    tx_d = (state_d == IDLE) ? 1'b1 : shift_d[0];
  end

  assign ready = ~hold_valid_q;
  assign busy  = (state_q != IDLE) | hold_valid_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Bench for simplez_uart_tx: directed frame/latency/reset checks on a recorded
// tx history plus a behavioural 8N1 receiver compared against written bytes.
module tb_simplez_uart_tx;

  localparam int BD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       wr;
  logic       ready;
  logic       busy;
  logic       tx;

  int checks;
  int errors;

  logic       txh[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         frame_err;
  bit         rx_act;
  int         rx_cnt;
  logic [9:0] rx_bits;

  simplez_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .wr    (wr),
    .ready (ready),
    .busy  (busy),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line history (one entry per clock, taken just after the edge) and a
  // mid-bit sampling receiver that aborts on reset.
  initial begin
    frame_err = 0;
    rx_act    = 1'b0;
    rx_cnt    = 0;
    rx_bits   = '0;
    forever begin
      @(posedge clk);
      #2;
      txh.push_back(tx);
      if (rst) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (tx == 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % BD) == (BD / 2)) begin
          rx_bits[rx_cnt / BD] = tx;
          if ((rx_cnt / BD) == 9) begin
            if (rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1) rx_q.push_back(rx_bits[8:1]);
            else frame_err++;
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data = b;
    wr   = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", ready, 1);
  endtask

  // Expected line level for a whole frame: start 0, data LSB first, stop 1.
  task automatic chk_frame(input int s, input logic [7:0] b, input string tag);
    int bitpos;
    logic expv;
    chk({tag, "_len"}, (txh.size() >= s + 10 * BD) ? 1 : 0, 1);
    if (txh.size() >= s + 10 * BD) begin
      for (int k = 0; k < 10 * BD; k++) begin
        bitpos = k / BD;
        if (bitpos == 0) expv = 1'b0;
        else if (bitpos == 9) expv = 1'b1;
        else expv = b[bitpos - 1];
        chk($sformatf("%s_c%0d", tag, k), txh[s + k], expv);
      end
    end
  endtask

  initial begin
    int s;
    int t;
    logic [7:0] rb;
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    wr   = 1'b0;
    data = '0;

    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x55: two-cycle latency to start bit, idle after 40 cycles.
    write_byte(8'h55);
    exp_q.push_back(8'h55);
    s = txh.size();
    chk("p55_ready_low", ready, 0);
    chk("p55_busy", busy, 1);
    chk("p55_no_early_fall", tx, 1);
    @(negedge clk);
    chk("p55_fall", tx, 0);
    repeat (39) @(negedge clk);
    chk("p55_busy_last", busy, 1);
    @(negedge clk);
    chk("p55_busy_end", busy, 0);
    chk("p55_ready_end", ready, 1);
    chk_frame(s, 8'h55, "p55");
    chk("p55_idle_after", txh[s + 40], 1);

    // Back-to-back 0x41/0x0F with an overrun write of 0xFF.
    write_byte(8'h41);
    exp_q.push_back(8'h41);
    s = txh.size();
    @(negedge clk);
    chk("b2b_ready_back", ready, 1);
    write_byte(8'h0F);
    exp_q.push_back(8'h0F);
    chk("b2b_ready_low", ready, 0);
    write_byte(8'hFF);
    chk("ovr_ready_low", ready, 0);
    repeat (80) @(negedge clk);
    chk("b2b_busy_end", busy, 0);
    chk_frame(s, 8'h41, "b2b_a");
    chk_frame(s + 40, 8'h0F, "b2b_b");
    chk("b2b_idle0", txh[s + 80], 1);
    chk("b2b_idle1", txh[s + 81], 1);

    // Reset during data bit 3 of 0xA5 with 0x77 pending.
    write_byte(8'hA5);
    @(negedge clk);
    write_byte(8'h77);
    repeat (16) @(negedge clk);
    chk("pre_rst_bit3", tx, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    data = 8'h3C;
    wr   = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    exp_q.push_back(8'h3C);
    s = txh.size();
    chk("post_rst_accept", ready, 0);
    chk("post_rst_no_early", txh[s - 1], 1);
    repeat (41) @(negedge clk);
    chk_frame(s, 8'h3C, "p3c");
    chk("p3c_busy_end", busy, 0);

    // Boundary bytes 0x00 then 0xFF, queued back-to-back.
    write_byte(8'h00);
    exp_q.push_back(8'h00);
    s = txh.size();
    wait_ready();
    write_byte(8'hFF);
    exp_q.push_back(8'hFF);
    repeat (85) @(negedge clk);
    chk_frame(s, 8'h00, "p00");
    chk_frame(s + 40, 8'hFF, "pff");
    chk("bnd_busy_end", busy, 0);

    // Random bytes, random gaps, random overrun attempts.
    for (int n = 0; n < 12; n++) begin
      wait_ready();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rb = 8'($urandom);
      write_byte(rb);
      exp_q.push_back(rb);
      chk("rnd_ready_low", ready, 0);
      if ($urandom_range(0, 1) == 1) write_byte(8'($urandom));
    end
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rnd_idle_timeout", busy, 0);
    repeat (4 * BD) @(negedge clk);

    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("rx_byte%0d", i), rx_q[i], exp_q[i]);
    end
    chk("rx_framing", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
